oflow_mem_rd_ctrl: RTL and testbench
====================================

Name: oflow_mem_rd_ctrl

Overview:
- Downstream read sequencer for the dual-port feature memory (all_mem, port 0).
- Walks the rows of the previous frame's stored features and issues synchronous reads.
- Unpacks each 290-bit row into two 145-bit bbox feature vectors, left half first, then right half.
- Streams the vectors one at a time to the similarity-metric stage over a valid/ready handshake, with frame-level start/done control.

Parameters:
- DATA_WIDTH_MEM, 290, memory row width; two bboxes per row.
- BBOX_WIDTH, DATA_WIDTH_MEM/2 (145), width of one bbox feature vector.
- ADDR_WIDTH, 8, memory address width; RAM_DEPTH = 1<<ADDR_WIDTH rows.
- NUM_BBOX_WIDTH, ADDR_WIDTH+2, width of the bbox count (max 2*RAM_DEPTH).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begin a frame read. Ignored unless IDLE.
- num_of_bbox  in  NUM_BBOX_WIDTH  bboxes stored for the frame; sampled on start.
- address_0  out  ADDR_WIDTH  memory read address.
- csb_0  out  1  memory chip select, active low.
- web_0  out  1  write enable, active low; held 1 (read only).
- oeb_0  out  1  output enable, active low; 0 in read-issue cycles.
- data_out_0  in  DATA_WIDTH_MEM  memory read data; valid one cycle after the address cycle.
- bbox_data  out  BBOX_WIDTH  current feature vector.
- bbox_id  out  ID_LEN  bbox_data[ID_LEN-1:0].
- bbox_valid  out  1  bbox_data valid.
- bbox_ready  in  1  consumer accepts; transfer = valid && ready.
- bbox_last  out  1  qualifies the final bbox of the frame.
- busy  out  1  high whenever not IDLE.
- done  out  1  one-cycle pulse after the last transfer, or after start with num_of_bbox==0.

Behaviour:
- Reset (sync, active-high):
  - FSM to IDLE; counters and row registers cleared.
  - csb_0=1, web_0=1, oeb_0=1, address_0=0.
  - bbox_valid=0, bbox_last=0, busy=0, done=0.
  - Reset mid-frame aborts immediately: no done, no further reads.
- Row layout:
  - Left bbox = row[289:145], emitted first; right bbox = row[144:0].
  - Within a bbox, ID occupies the low ID_LEN bits.
  - For odd num_of_bbox, the right half of the final row is never emitted.
- FSM states: IDLE, RD_ISSUE, RD_CAPTURE, SEND_L, SEND_R, FIN.
  - IDLE: on start, latch num_of_bbox, clear row_addr and bbox_cnt. If num==0 go to FIN, else go to RD_ISSUE.
  - RD_ISSUE: address_0=row_addr, csb_0=0, oeb_0=0 for exactly one cycle; next RD_CAPTURE.
  - RD_CAPTURE: latch data_out_0 into row_reg; row_addr++; next SEND_L.
  - SEND_L: bbox_valid=1, bbox_data=row_reg[289:145]. On transfer, bbox_cnt++.
    - If it was the last bbox, go to FIN.
    - Otherwise go to SEND_R.
  - SEND_R: bbox_valid=1, bbox_data=row_reg[144:0]. On transfer, bbox_cnt++.
    - If it was the last bbox, go to FIN.
    - Otherwise go to RD_ISSUE.
  - FIN: done=1 for one cycle; next IDLE.
- Handshake rules:
  - bbox_data and bbox_last hold stable while valid && !ready.
  - valid never drops without a transfer.
  - bbox_last = valid && (bbox_cnt == num-1).
- Latency: start sampled at cycle 0.
  - Address issued at cycle 1; first valid at cycle 3.
  - With ready held high, the non-prefetch throughput is 2 bboxes per 4 cycles.
- Boundary conditions:
  - num_of_bbox=2*RAM_DEPTH: row_addr reaches RAM_DEPTH-1 and the frame ends with no wrap-around read.
  - Values above 2*RAM_DEPTH are clamped to 2*RAM_DEPTH.
  - start while busy is ignored.
  - start coincident with reset: reset wins.

Optional Feature:
- Macro OFLOW_MEM_RD_PREFETCH_EN.
- When defined:
  - In the SEND_L transfer cycle, if another row remains, issue a read of row_addr (csb_0=0, oeb_0=0).
  - Capture data_out_0 into pre_reg on the following cycle, unconditionally, even if SEND_R is stalled.
  - A SEND_R transfer with pre_reg full loads row_reg from pre_reg and moves directly to SEND_L, skipping RD_ISSUE and RD_CAPTURE.
  - Steady-state throughput is 1 bbox/cycle with ready high.
- When undefined: no pre_reg is built, and the behaviour is exactly as above.

Decomposition:
- Package oflow_mem_rd_pkg holds:
  - the FSM state enum;
  - BBOX_WIDTH, and ID_LEN/CM_CONCATE_LEN/POSITION_CONCATE_LEN, mirrored from the feature-extraction defines;
  - helper functions row_left() and row_right().
- One natural sub-module, oflow_mem_rd_row_buf: row_reg plus optional pre_reg, with load/select/full logic.

Test Plan:
- num_of_bbox=4, ready=1, start at cycle 0, no prefetch:
  - reads of addr 0 at cycle 1 and addr 1 at cycle 5;
  - valid at cycles 3, 4, 7, 8 with bbox order L0, R0, L1, R1;
  - last at cycle 8, done at cycle 9.
- Same stimulus with OFLOW_MEM_RD_PREFETCH_EN:
  - addr 1 is read at cycle 3;
  - valid at cycles 3 to 6 consecutively;
  - done at cycle 7.
- num_of_bbox=3: three transfers L0, R0, L1; last on L1; no read of row 2; done follows.
- num_of_bbox=0: no csb_0 assertion; done pulses at cycle 1; busy is high only in FIN.
- ready low for 5 cycles on R0: bbox_data, bbox_valid and bbox_last are stable throughout; exactly one transfer occurs.
- Reset asserted in SEND_L of row 1: next cycle is IDLE with valid=0 and csb_0=1; no done; a new start works normally.

Source files
------------

// File: rtl/oflow_mem_rd_pkg.sv
// Shared state encoding, feature-vector geometry and row unpacking helpers for the
// all_mem port-0 read sequencer.
package oflow_mem_rd_pkg;

    localparam int unsigned DATA_WIDTH_MEM = 290;
    localparam int unsigned BBOX_WIDTH     = DATA_WIDTH_MEM / 2;

    // Mirrored from the feature-extraction defines; together they fill one bbox vector.
    localparam int unsigned ID_LEN               = 9;
    localparam int unsigned CM_CONCATE_LEN       = 96;
    localparam int unsigned POSITION_CONCATE_LEN = 40;

    typedef enum logic [2:0] {
        StIdle,
        StRdIssue,
        StRdCapture,
        StSendL,
        StSendR,
        StFin
    } rd_state_e;

    function automatic logic [BBOX_WIDTH-1:0] row_left(input logic [DATA_WIDTH_MEM-1:0] row);
        return row[DATA_WIDTH_MEM-1 -: BBOX_WIDTH];
    endfunction

    function automatic logic [BBOX_WIDTH-1:0] row_right(input logic [DATA_WIDTH_MEM-1:0] row);
        return row[BBOX_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/oflow_mem_rd_row_buf.sv
// Row holding register plus an optional prefetch register (OFLOW_MEM_RD_PREFETCH_EN),
// with left/right half selection onto the bbox data path.
module oflow_mem_rd_row_buf
    import oflow_mem_rd_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_WIDTH_MEM-1:0] data_in,
    input  logic                      load_row,
    input  logic                      load_pre,
    input  logic                      swap,
    input  logic                      sel_right,
    output logic [BBOX_WIDTH-1:0]     bbox_data,
    output logic                      pre_full
);

    logic [DATA_WIDTH_MEM-1:0] row_reg;

`ifdef OFLOW_MEM_RD_PREFETCH_EN
    logic [DATA_WIDTH_MEM-1:0] pre_reg;
    logic                      pre_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            row_reg   <= '0;
            pre_reg   <= '0;
            pre_valid <= 1'b0;
        end else begin
            if (load_pre) begin
                pre_reg <= data_in;
            end
            // A capture landing in the same cycle as the swap bypasses pre_reg.
            if (swap) begin
                row_reg <= load_pre ? data_in : pre_reg;
            end else if (load_row) begin
                row_reg <= data_in;
            end
            if (swap) begin
                pre_valid <= 1'b0;
            end else if (load_pre) begin
                pre_valid <= 1'b1;
            end
        end
    end

    assign pre_full = pre_valid;
`else
    logic unused_pf;

    always_ff @(posedge clk) begin
        if (reset) begin
            row_reg <= '0;
        end else if (load_row) begin
            row_reg <= data_in;
        end
    end

    assign pre_full  = 1'b0;
    assign unused_pf = ^{load_pre, swap};
`endif

    assign bbox_data = sel_right ? row_right(row_reg) : row_left(row_reg);

endmodule

// File: rtl/oflow_mem_rd_ctrl.sv
// Frame read sequencer for all_mem port 0: reads stored rows and streams their two bbox
// halves over valid/ready. OFLOW_MEM_RD_PREFETCH_EN overlaps the next row read with SEND_R.
module oflow_mem_rd_ctrl
    import oflow_mem_rd_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned NUM_BBOX_WIDTH = ADDR_WIDTH + 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [NUM_BBOX_WIDTH-1:0] num_of_bbox,
    output logic [ADDR_WIDTH-1:0]     address_0,
    output logic                      csb_0,
    output logic                      web_0,
    output logic                      oeb_0,
    input  logic [DATA_WIDTH_MEM-1:0] data_out_0,
    output logic [BBOX_WIDTH-1:0]     bbox_data,
    output logic [ID_LEN-1:0]         bbox_id,
    output logic                      bbox_valid,
    input  logic                      bbox_ready,
    output logic                      bbox_last,
    output logic                      busy,
    output logic                      done
);

    localparam logic [NUM_BBOX_WIDTH-1:0] MAX_BBOX = NUM_BBOX_WIDTH'(2 << ADDR_WIDTH);
    localparam logic [NUM_BBOX_WIDTH-1:0] CNT_ONE  = NUM_BBOX_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]       ROW_ONE  = (ADDR_WIDTH + 1)'(1);

    rd_state_e                 state;
    logic [NUM_BBOX_WIDTH-1:0] num_q;
    logic [NUM_BBOX_WIDTH-1:0] bbox_cnt;
    logic [NUM_BBOX_WIDTH-1:0] num_clamped;
    logic [NUM_BBOX_WIDTH-1:0] last_idx;
    logic [NUM_BBOX_WIDTH-1:0] rows_x2;
    // One extra bit so the count of consumed rows never wraps at RAM_DEPTH.
    logic [ADDR_WIDTH:0]       row_addr;
    logic                      csb_q;
    logic                      oeb_q;
    logic                      xfer;
    logic                      is_last;
    logic                      rows_remain;
    logic                      pf_issue;
    logic                      pf_pending;
    logic                      pre_full;
    logic                      swap;

    assign num_clamped = (num_of_bbox > MAX_BBOX) ? MAX_BBOX : num_of_bbox;
    assign xfer        = bbox_valid & bbox_ready;
    assign last_idx    = num_q - CNT_ONE;
    assign is_last     = (bbox_cnt == last_idx);
    assign rows_x2     = NUM_BBOX_WIDTH'({row_addr, 1'b0});
    assign rows_remain = (rows_x2 < num_q);

`ifdef OFLOW_MEM_RD_PREFETCH_EN
    // The prefetch read rides on the SEND_L transfer itself, so it follows ready directly.
    assign pf_issue = ~reset & (state == StSendL) & xfer & rows_remain;
    assign swap     = (state == StSendR) & xfer & ~is_last & (pf_pending | pre_full);

    always_ff @(posedge clk) begin
        if (reset) begin
            pf_pending <= 1'b0;
        end else begin
            pf_pending <= pf_issue;
        end
    end
`else
    logic unused_rows;

    assign pf_issue    = 1'b0;
    assign swap        = 1'b0;
    assign pf_pending  = 1'b0;
    assign unused_rows = ^{rows_remain, pre_full};
`endif

    assign address_0 = row_addr[ADDR_WIDTH-1:0];
    assign csb_0     = csb_q & ~pf_issue;
    assign oeb_0     = oeb_q & ~pf_issue;
    assign web_0     = 1'b1;
    assign bbox_last = bbox_valid & is_last;
    assign bbox_id   = bbox_data[ID_LEN-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            num_q      <= '0;
            bbox_cnt   <= '0;
            row_addr   <= '0;
            csb_q      <= 1'b1;
            oeb_q      <= 1'b1;
            bbox_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        num_q    <= num_clamped;
                        bbox_cnt <= '0;
                        row_addr <= '0;
                        busy     <= 1'b1;
                        if (num_clamped == '0) begin
                            state <= StFin;
                            done  <= 1'b1;
                        end else begin
                            state <= StRdIssue;
                            csb_q <= 1'b0;
                            oeb_q <= 1'b0;
                        end
                    end
                end
                StRdIssue: begin
                    state <= StRdCapture;
                    csb_q <= 1'b1;
                    oeb_q <= 1'b1;
                end
                StRdCapture: begin
                    state      <= StSendL;
                    row_addr   <= row_addr + ROW_ONE;
                    bbox_valid <= 1'b1;
                end
                StSendL: begin
                    if (xfer) begin
                        bbox_cnt <= bbox_cnt + CNT_ONE;
                        if (pf_issue) begin
                            row_addr <= row_addr + ROW_ONE;
                        end
                        if (is_last) begin
                            state      <= StFin;
                            bbox_valid <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            state <= StSendR;
                        end
                    end
                end
                StSendR: begin
                    if (xfer) begin
                        bbox_cnt <= bbox_cnt + CNT_ONE;
                        if (is_last) begin
                            state      <= StFin;
                            bbox_valid <= 1'b0;
                            done       <= 1'b1;
                        end else if (swap) begin
                            state <= StSendL;
                        end else begin
                            state      <= StRdIssue;
                            bbox_valid <= 1'b0;
                            csb_q      <= 1'b0;
                            oeb_q      <= 1'b0;
                        end
                    end
                end
                StFin: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= StIdle;
                    busy       <= 1'b0;
                    bbox_valid <= 1'b0;
                    csb_q      <= 1'b1;
                    oeb_q      <= 1'b1;
                end
            endcase
        end
    end

    oflow_mem_rd_row_buf u_row_buf (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_out_0),
        .load_row  (state == StRdCapture),
        .load_pre  (pf_pending),
        .swap      (swap),
        .sel_right (state == StSendR),
        .bbox_data (bbox_data),
        .pre_full  (pre_full)
    );

endmodule

// File: tb/tb_oflow_mem_rd_ctrl.sv
// Scoreboard bench for oflow_mem_rd_ctrl: expected bbox stream derived from the memory image
// and the row layout, checked by a negedge monitor alongside read, timing and handshake rules.
module tb_oflow_mem_rd_ctrl;
    import oflow_mem_rd_pkg::*;

    localparam int unsigned ADDR_WIDTH     = 8;
    localparam int unsigned NUM_BBOX_WIDTH = ADDR_WIDTH + 2;
    localparam int          RAM_DEPTH      = 1 << ADDR_WIDTH;
`ifdef OFLOW_MEM_RD_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic                      clk;
    logic                      reset;
    logic                      start;
    logic [NUM_BBOX_WIDTH-1:0] num_of_bbox;
    logic [ADDR_WIDTH-1:0]     address_0;
    logic                      csb_0;
    logic                      web_0;
    logic                      oeb_0;
    logic [DATA_WIDTH_MEM-1:0] data_out_0;
    logic [BBOX_WIDTH-1:0]     bbox_data;
    logic [ID_LEN-1:0]         bbox_id;
    logic                      bbox_valid;
    logic                      bbox_ready;
    logic                      bbox_last;
    logic                      busy;
    logic                      done;

    typedef struct {
        logic [BBOX_WIDTH-1:0] data;
        logic                  last;
    } exp_t;

    exp_t                      exp_q[$];
    logic [DATA_WIDTH_MEM-1:0] mem [RAM_DEPTH];
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cyc = 0;
    int first_valid = -1;
    int done_rel = -1;
    int last_rel = -1;
    int frame_rd = 0;
    int xfers = 0;
    int busy_cnt = 0;
    int rows_lim = 0;
    int rd_rel[2];
    int rd_addr[2];
    logic                  hold_prev = 1'b0;
    logic [BBOX_WIDTH-1:0] prev_data;
    logic                  prev_last;

    oflow_mem_rd_ctrl #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .NUM_BBOX_WIDTH (NUM_BBOX_WIDTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .num_of_bbox (num_of_bbox),
        .address_0   (address_0),
        .csb_0       (csb_0),
        .web_0       (web_0),
        .oeb_0       (oeb_0),
        .data_out_0  (data_out_0),
        .bbox_data   (bbox_data),
        .bbox_id     (bbox_id),
        .bbox_valid  (bbox_valid),
        .bbox_ready  (bbox_ready),
        .bbox_last   (bbox_last),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory model: data appears the cycle after the address cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!csb_0 && web_0) begin
            data_out_0 <= mem[address_0];
        end
    end

    task automatic chk_int(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    task automatic chk_vec(input string nm, input logic [BBOX_WIDTH-1:0] act,
                           input logic [BBOX_WIDTH-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk_int("hold_valid", int'(bbox_valid), 1);
                chk_vec("hold_data", bbox_data, prev_data);
                chk_int("hold_last", int'(bbox_last), int'(prev_last));
            end
            hold_prev = bbox_valid && !bbox_ready;
            prev_data = bbox_data;
            prev_last = bbox_last;
            if (bbox_valid && first_valid < 0) first_valid = cyc - start_cyc;
            if (busy) busy_cnt++;
            if (bbox_valid && bbox_ready) begin
                if (bbox_last) last_rel = cyc - start_cyc;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL extra_xfer: got transfer of %0h, none expected", bbox_data);
                end else begin
                    e = exp_q.pop_front();
                    chk_vec("bbox_data", bbox_data, e.data);
                    chk_vec("bbox_id", BBOX_WIDTH'(bbox_id), BBOX_WIDTH'(e.data[ID_LEN-1:0]));
                    chk_int("bbox_last", int'(bbox_last), int'(e.last));
                end
                xfers++;
            end
            if (done) begin
                done_rel = cyc - start_cyc;
                chk_int("done_queue_empty", exp_q.size(), 0);
            end
            if (!csb_0) begin
                if (frame_rd < 2) begin
                    rd_rel[frame_rd]  = cyc - start_cyc;
                    rd_addr[frame_rd] = int'(address_0);
                end
                frame_rd++;
                chk_int("rd_oeb", int'(oeb_0), 0);
                chk_int("rd_web", int'(web_0), 1);
                chk_int("rd_in_range", int'(int'(address_0) < rows_lim), 1);
            end
        end
    end

    task automatic push_exp(input int ne);
        exp_t e;
        logic [DATA_WIDTH_MEM-1:0] row;
        for (int i = 0; i < ne; i++) begin
            row    = mem[i / 2];
            e.data = (i % 2 == 0) ? row[DATA_WIDTH_MEM-1 -: BBOX_WIDTH] : row[BBOX_WIDTH-1:0];
            e.last = (i == ne - 1);
            exp_q.push_back(e);
        end
        first_valid = -1;
        done_rel    = -1;
        last_rel    = -1;
        frame_rd    = 0;
        xfers       = 0;
        busy_cnt    = 0;
        rd_rel[0]   = -1;
        rd_rel[1]   = -1;
        rd_addr[0]  = -1;
        rd_addr[1]  = -1;
        rows_lim    = (ne + 1) / 2;
    endtask

    // mode 0: ready high; 1: random ready; 2: ready low for 5 cycles on R0.
    task automatic run_frame(input int n, input int mode, input bit spurious);
        int ne;
        int stall;
        ne    = (n > 2 * RAM_DEPTH) ? 2 * RAM_DEPTH : n;
        stall = 0;
        push_exp(ne);
        bbox_ready  = 1'b1;
        start       = 1'b1;
        num_of_bbox = NUM_BBOX_WIDTH'(n);
        start_cyc   = cyc;
        @(posedge clk);
        #1;
        for (int c = 0; c < 6000 && done_rel < 0; c++) begin
            case (mode)
                1: bbox_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (xfers == 1 && stall < 5) begin
                        bbox_ready = 1'b0;
                        stall++;
                    end else begin
                        bbox_ready = 1'b1;
                    end
                end
                default: bbox_ready = 1'b1;
            endcase
            start       = spurious && (c == 4);
            num_of_bbox = NUM_BBOX_WIDTH'($urandom_range(1, 8));
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        chk_int("done_seen", int'(done_rel >= 0), 1);
        chk_int("read_count", frame_rd, (ne + 1) / 2);
        chk_int("xfer_count", xfers, ne);
        exp_q.delete();
    endtask

    initial begin
        logic [319:0] t;
        for (int r = 0; r < RAM_DEPTH; r++) begin
            for (int w = 0; w < 10; w++) t[w*32 +: 32] = $urandom;
            mem[r] = t[DATA_WIDTH_MEM-1:0];
        end
        reset       = 1'b1;
        start       = 1'b0;
        num_of_bbox = '0;
        bbox_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_int("rst_csb", int'(csb_0), 1);
        chk_int("rst_oeb", int'(oeb_0), 1);
        chk_int("rst_web", int'(web_0), 1);
        chk_int("rst_addr", int'(address_0), 0);
        chk_int("rst_valid", int'(bbox_valid), 0);
        chk_int("rst_last", int'(bbox_last), 0);
        chk_int("rst_busy", int'(busy), 0);
        chk_int("rst_done", int'(done), 0);

        // Start coincident with reset must be ignored.
        start       = 1'b1;
        num_of_bbox = NUM_BBOX_WIDTH'(5);
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk_int("start_in_reset_busy", int'(busy), 0);
        chk_int("start_in_reset_csb", int'(csb_0), 1);

        run_frame(4, 0, 1'b0);
        chk_int("n4_first_valid", first_valid, 3);
        chk_int("n4_last_cycle", last_rel, PF ? 6 : 8);
        chk_int("n4_done_cycle", done_rel, PF ? 7 : 9);
        chk_int("n4_rd0_cycle", rd_rel[0], 1);
        chk_int("n4_rd0_addr", rd_addr[0], 0);
        chk_int("n4_rd1_cycle", rd_rel[1], PF ? 3 : 5);
        chk_int("n4_rd1_addr", rd_addr[1], 1);

        run_frame(3, 0, 1'b0);
        chk_int("n3_last_cycle", last_rel, PF ? 5 : 7);
        chk_int("n3_done_cycle", done_rel, PF ? 6 : 8);

        run_frame(0, 0, 1'b0);
        chk_int("n0_done_cycle", done_rel, 1);
        chk_int("n0_busy_cycles", busy_cnt, 1);

        run_frame(4, 2, 1'b0);

        // Reset while presenting L1 aborts the frame.
        push_exp(4);
        bbox_ready  = 1'b1;
        start       = 1'b1;
        num_of_bbox = NUM_BBOX_WIDTH'(4);
        start_cyc   = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 0; c < 40 && !(xfers == 2 && bbox_valid); c++) begin
            @(posedge clk);
            #1;
        end
        chk_int("abort_reached_l1", int'(xfers == 2 && bbox_valid), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk_int("abort_valid", int'(bbox_valid), 0);
        chk_int("abort_csb", int'(csb_0), 1);
        chk_int("abort_busy", int'(busy), 0);
        exp_q.delete();
        done_rel = -1;
        repeat (10) @(posedge clk);
        #1;
        chk_int("abort_no_done", done_rel, -1);
        chk_int("abort_no_reads", frame_rd, 2);

        for (int k = 0; k < 12; k++) begin
            int n;
            n = $urandom_range(1, 24);
            run_frame(n, 1, (n >= 8) && (k % 2 == 1));
        end
        run_frame(2 * RAM_DEPTH, 0, 1'b0);
        run_frame(700, 1, 1'b0);
        run_frame(5, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
